// File: rtl/halfbridge_pwm_gen.sv
// Fixed 50% duty complementary square wave with a run-time half-period; outputs are registered, one cycle behind i_enable.
// No backpressure. New half-periods apply at period starts only, and a stop always finishes the current period.
module halfbridge_pwm_gen #(
  parameter int CNT_W  = 16,
  parameter int HP_MIN = 16,
  parameter int HP_MAX = 65535
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_half_period,
  input  logic             i_load,
  output logic             o_sw_p,
  output logic             o_sw_n,
  output logic             o_sync,
  output logic             o_running,
  output logic [CNT_W-1:0] o_hp_active
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] HP_MIN_V = CNT_W'(HP_MIN);
  localparam logic [CNT_W-1:0] HP_MAX_V = CNT_W'(HP_MAX);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] hp_clamped;
  logic [CNT_W-1:0] next_active;
  logic             phase_done;

  always_comb begin
    hp_clamped = i_half_period;
    if (i_half_period < HP_MIN_V)
      hp_clamped = HP_MIN_V;
    else if (i_half_period > HP_MAX_V)
      hp_clamped = HP_MAX_V;
  end

  // A load coinciding with a period start bypasses the shadow register.
  assign next_active = i_load ? hp_clamped : shadow;
  assign phase_done  = (cnt == o_hp_active - CNT_W'(1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= HP_MIN_V;
      o_hp_active <= HP_MIN_V;
      o_sw_p      <= 1'b0;
      o_sw_n      <= 1'b0;
      o_sync      <= 1'b0;
      o_running   <= 1'b0;
    end else begin
      o_sync <= 1'b0;
      if (i_load)
        shadow <= hp_clamped;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_enable) begin
            state       <= HIGH;
            o_sw_p      <= 1'b1;
            o_sw_n      <= 1'b0;
            o_sync      <= 1'b1;
            o_running   <= 1'b1;
            o_hp_active <= next_active;
          end
        end

        HIGH: begin
          if (phase_done) begin
            state  <= LOW;
            cnt    <= '0;
            o_sw_p <= 1'b0;
            o_sw_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LOW: begin
          if (phase_done) begin
            cnt    <= '0;
            o_sw_n <= 1'b0;
            if (i_enable) begin
              state       <= HIGH;
              o_sw_p      <= 1'b1;
              o_sync      <= 1'b1;
              o_hp_active <= next_active;
            end else begin
              state     <= IDLE;
              o_sw_p    <= 1'b0;
              o_running <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          o_sw_p    <= 1'b0;
          o_sw_n    <= 1'b0;
          o_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halfbridge_pwm_gen.sv
// Random and directed stimulus against a period-position reference model of the half-bridge generator.
module tb_halfbridge_pwm_gen;

  localparam int CNT_W  = 16;
  localparam int HP_MIN = 16;
  localparam int HP_MAX = 1000;

  logic             i_clock = 1'b0;
  logic             i_reset_n;
  logic             i_enable;
  logic [CNT_W-1:0] i_half_period;
  logic             i_load;
  logic             o_sw_p;
  logic             o_sw_n;
  logic             o_sync;
  logic             o_running;
  logic [CNT_W-1:0] o_hp_active;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  // Model: running flag, position inside the current full period, active and pending half-period
  int m_run, m_pos, m_act, m_shadow;

  halfbridge_pwm_gen #(.CNT_W(CNT_W), .HP_MIN(HP_MIN), .HP_MAX(HP_MAX)) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_enable      (i_enable),
    .i_half_period (i_half_period),
    .i_load        (i_load),
    .o_sw_p        (o_sw_p),
    .o_sw_n        (o_sw_n),
    .o_sync        (o_sync),
    .o_running     (o_running),
    .o_hp_active   (o_hp_active)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int hp);
    if (hp < HP_MIN) return HP_MIN;
    if (hp > HP_MAX) return HP_MAX;
    return hp;
  endfunction

  task automatic model_reset();
    m_run    = 0;
    m_pos    = 0;
    m_act    = HP_MIN;
    m_shadow = HP_MIN;
  endtask

  task automatic model_edge();
    int pending;
    pending = i_load ? clamp(int'(i_half_period)) : m_shadow;
    if (m_run == 0) begin
      if (i_enable) begin
        m_run = 1;
        m_pos = 0;
        m_act = pending;
      end
    end else if (m_pos == 2 * m_act - 1) begin
      m_pos = 0;
      if (i_enable) m_act = pending;
      else          m_run = 0;
    end else begin
      m_pos++;
    end
    m_shadow = pending;
  endtask

  task automatic compare_all();
    check("sw_p",    32'(o_sw_p),      32'(m_run != 0 && m_pos < m_act));
    check("sw_n",    32'(o_sw_n),      32'(m_run != 0 && m_pos >= m_act));
    check("sync",    32'(o_sync),      32'(m_run != 0 && m_pos == 0));
    check("running", 32'(o_running),   32'(m_run != 0));
    check("hp_act",  32'(o_hp_active), 32'(m_act));
    check("overlap", 32'(o_sw_p & o_sw_n), 32'd0);
  endtask

  task automatic step();
    @(posedge i_clock);
    if (!i_reset_n) model_reset();
    else            model_edge();
    #1;
    compare_all();
  endtask

  task automatic load_once(input int hp);
    i_load        = 1'b1;
    i_half_period = CNT_W'(hp);
    step();
    i_load = 1'b0;
  endtask

  initial begin
    int g;
    i_reset_n     = 1'b0;
    i_enable      = 1'b0;
    i_load        = 1'b0;
    i_half_period = '0;
    model_reset();
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_sw_p", 32'(o_sw_p), 32'd0);
    check("rst_sw_n", 32'(o_sw_n), 32'd0);
    check("rst_sync", 32'(o_sync), 32'd0);
    check("rst_run",  32'(o_running), 32'd0);
    check("rst_hp",   32'(o_hp_active), 32'(HP_MIN));
    i_reset_n = 1'b1;
    step();

    // Start at 100 with load and enable together
    i_enable = 1'b1;
    load_once(100);
    check("start_hp", 32'(o_hp_active), 32'd100);
    check("start_sync", 32'(o_sync), 32'd1);
    repeat (399) step();

    // Load 50 in the middle of a HIGH phase
    g = 0;
    while (!(m_run != 0 && m_pos == 30) && g < 300) begin step(); g++; end
    check("wait_mid_high", 32'(g < 300), 32'd1);
    load_once(50);
    repeat (400) step();
    check("hp_50", 32'(o_hp_active), 32'd50);

    // Clamping
    load_once(3);
    repeat (150) step();
    check("clamp_3", 32'(o_hp_active), 32'd16);
    load_once(5000);
    repeat (100) step();
    check("clamp_5000", 32'(o_hp_active), 32'd1000);
    load_once(0);
    repeat (2100) step();
    check("clamp_0", 32'(o_hp_active), 32'd16);

    // Stop 10 cycles into a HIGH phase at 100
    load_once(100);
    g = 0;
    while (!(m_run != 0 && m_pos == 0 && m_act == 100) && g < 300) begin step(); g++; end
    check("wait_sync100", 32'(g < 300), 32'd1);
    repeat (10) step();
    i_enable = 1'b0;
    repeat (189) step();
    check("stop_still_low", 32'(o_sw_n), 32'd1);
    repeat (6) step();
    check("stop_idle", 32'(o_running), 32'd0);
    check("stop_sw_p", 32'(o_sw_p), 32'd0);

    // Asynchronous reset in the middle of LOW
    i_enable = 1'b1;
    g = 0;
    while (!(m_run != 0 && m_pos == m_act + 5) && g < 500) begin step(); g++; end
    check("wait_low", 32'(g < 500), 32'd1);
    check("pre_rst_sw_n", 32'(o_sw_n), 32'd1);
    #3;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    check("async_sw_n", 32'(o_sw_n), 32'd0);
    check("async_sw_p", 32'(o_sw_p), 32'd0);
    step();
    step();
    i_reset_n = 1'b1;
    step();
    check("restart_sw_p", 32'(o_sw_p), 32'd1);
    check("restart_hp", 32'(o_hp_active), 32'(HP_MIN));

    // Load coincident with the LOW->HIGH transfer bypasses the shadow
    load_once(100);
    g = 0;
    while (!(m_run != 0 && m_act == 100 && m_pos == 199) && g < 500) begin step(); g++; end
    check("wait_end_low", 32'(g < 500), 32'd1);
    load_once(40);
    check("bypass_hp", 32'(o_hp_active), 32'd40);
    check("bypass_sync", 32'(o_sync), 32'd1);
    repeat (39) step();
    check("bypass_high_end", 32'(o_sw_p), 32'd1);
    step();
    check("bypass_low_start", 32'(o_sw_n), 32'd1);

    // Random phase
    for (int n = 0; n < 15000; n++) begin
      i_load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0)
        i_half_period = CNT_W'($urandom_range(1001, 8000));
      else
        i_half_period = CNT_W'($urandom_range(0, 120));
      if ($urandom_range(0, 299) == 0) i_enable = ~i_enable;
      step();
    end
    i_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/halfbridge_pwm_gen.md
Name: halfbridge_pwm_gen

Overview:
Variable-frequency, fixed 50 % duty square-wave generator for the resonant half-bridge. It produces the complementary raw switching commands o_sw_p / o_sw_n. Each command feeds its own downstream dead-time stage, which adds rising-edge delay per leg. The half-period is programmable at run time. Updates apply only at full-period boundaries to keep volt-second balance. Stop requests always complete the current period.

Parameters:
CNT_W, 16, width of half-period input and internal counter
HP_MIN, 16, minimum half-period in clock cycles (clamp floor, ≥2)
HP_MAX, 65535, maximum half-period in clock cycles (clamp ceiling, ≤2^CNT_W−1)

Ports:
i_clock  input  1  system clock; all logic on rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_enable  input  1  run request; level-sensitive
i_half_period  input  CNT_W  requested half-period in clock cycles
i_load  input  1  one-cycle strobe; captures i_half_period into the shadow register
o_sw_p  output  1  high-side switching command (to dead-time stage)
o_sw_n  output  1  low-side switching command (to dead-time stage)
o_sync  output  1  one-cycle pulse coincident with each o_sw_p rising edge
o_running  output  1  high whenever state ≠ IDLE
o_hp_active  output  CNT_W  half-period currently in use

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; all outputs 0.
  - counter = 0; shadow = HP_MIN; o_hp_active = HP_MIN.
  - Mid-operation assert forces o_sw_p = o_sw_n = 0 immediately, without waiting for a clock.
- All outputs are registered. o_sw_p and o_sw_n are never 1 together, including at state transitions.
- Clamp: on i_load, shadow ← HP_MIN if i_half_period < HP_MIN; HP_MAX if > HP_MAX; else i_half_period.
- Period-boundary transfer: active (o_hp_active) ← shadow on every entry to HIGH.
  - If i_load is high in the same cycle as the transfer, the newly clamped value bypasses the shadow and becomes active directly.
- States:
  - IDLE:
    - Outputs 0, counter held at 0.
    - If i_enable = 1 at edge N: after edge N, state = HIGH, o_sw_p = 1, o_sync = 1 (one cycle only), active transferred, counter = 0.
  - HIGH:
    - o_sw_p = 1, counter += 1 each cycle.
    - When counter = active−1: next state = LOW, counter = 0, o_sw_p = 0, o_sw_n = 1.
    - o_sw_p is therefore high for exactly `active` cycles.
  - LOW:
    - o_sw_n = 1, counter += 1 each cycle.
    - When counter = active−1:
      - If i_enable = 1: next state = HIGH, with transfer and o_sync pulse.
      - Else: next state = IDLE, all outputs 0.
- i_enable deasserted in HIGH or LOW does not truncate the current period. The period finishes, then the block returns to IDLE. Re-asserting before the LOW end continues seamlessly.
- i_enable is not latched in IDLE; a pulse shorter than one clock cycle may be missed.
- Period = 2·active cycles. Duty is exactly 50 % for every complete period, because active never changes inside a period.
- Counter compare uses equality on CNT_W bits. Clamping guarantees active ≥ 2, so no wrap-around is possible.
- i_load while IDLE updates shadow only. The value takes effect at the next start.

Test Plan:
- Reset, then i_load with 100 and i_enable = 1:
  - o_sw_p high 100 cycles, then o_sw_n high 100 cycles, repeating.
  - o_sync pulses every 200 cycles; o_hp_active = 100.
  - Check o_sw_p & o_sw_n never both 1.
- Mid-HIGH i_load of 50 while running at 100:
  - Current HIGH and LOW stay 100 cycles each.
  - Next period is 50/50; o_hp_active changes to 50 at the o_sync cycle.
- Clamp checks with HP_MIN = 16:
  - Load 3 → o_hp_active = 16 and 32-cycle period.
  - Load 0 → 16.
  - With HP_MAX = 1000, load 5000 → 1000.
- Deassert i_enable 10 cycles into HIGH at half-period 100:
  - HIGH completes 100 cycles, LOW completes 100 cycles.
  - Then IDLE with outputs 0 and o_running = 0.
- Assert i_reset_n = 0 mid-LOW: o_sw_n drops to 0 without a clock edge. After release with i_enable = 1, restart is at HP_MIN in HIGH.
- i_load of 40 in the same cycle as the LOW→HIGH transition: the new HIGH phase is 40 cycles (bypass), confirmed by o_hp_active = 40 during that HIGH.
